// File: rtl/tone_pkg.sv
// Definitions shared between the voice-tone adjuster and its frame seam smoother.
package tone_pkg;

    localparam int TONE_FRAME_LEN = 1024;
    localparam int SAMPLE_W       = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        UNSYNC   = 2'd0,
        FADE_IN  = 2'd1,
        PASS     = 2'd2,
        FADE_OUT = 2'd3
    } seam_state_e;

endpackage

// File: rtl/seam_gain_mul.sv
// Two-stage registered signed sample * unsigned gain, scaled down by 2^GAIN_SH (floor).
module seam_gain_mul #(
    parameter int DATA_WIDTH = 16,
    parameter int GAIN_SH    = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] x_i,
    input  logic        [GAIN_SH:0]      gain_i,
    output logic signed [DATA_WIDTH-1:0] y_o
);

    localparam int PROD_W = DATA_WIDTH + GAIN_SH + 2;

    logic signed [DATA_WIDTH-1:0] x_p0_q;
    logic        [GAIN_SH:0]      gain_p0_q;
    logic signed [DATA_WIDTH-1:0] y_p1_q;
    logic signed [DATA_WIDTH-1:0] y_d;

    // Arithmetic shift floors toward minus infinity; |result| <= |x|+1 so no saturation.
    function automatic logic signed [DATA_WIDTH-1:0] scale_floor(
        input logic signed [DATA_WIDTH-1:0] x,
        input logic        [GAIN_SH:0]      g
    );
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(x) * PROD_W'($signed({1'b0, g}));
        return DATA_WIDTH'(prod >>> GAIN_SH);
    endfunction

    assign y_d = scale_floor(x_p0_q, gain_p0_q);

    // stage 1: operands, stage 2: scaled product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_p0_q    <= '0;
            gain_p0_q <= '0;
            y_p1_q    <= '0;
        end else begin
            x_p0_q    <= x_i;
            gain_p0_q <= gain_i;
            y_p1_q    <= y_d;
        end
    end

    assign y_o = y_p1_q;

endmodule

// File: rtl/frame_seam_smoother.sv
// Linear fade-out/fade-in around tone-adjuster frame boundaries, 2-cycle latency.
// Optional SEAM_STATS_EN adds the seam_cnt output counting fade-in entries.
module frame_seam_smoother
    import tone_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = TONE_FRAME_LEN,
    parameter int FADE_LEN   = 32
) (
    input  logic                         sck,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         frame_sync,
    input  logic signed [DATA_WIDTH-1:0] ldata_in,
    input  logic signed [DATA_WIDTH-1:0] rdata_in,
    output logic signed [DATA_WIDTH-1:0] ldata_out,
    output logic signed [DATA_WIDTH-1:0] rdata_out,
    output logic                         seam_active
`ifdef SEAM_STATS_EN
    ,
    output logic [15:0]                  seam_cnt
`endif
);

    localparam int GAIN_SH = $clog2(FADE_LEN);
    localparam int P_W     = $clog2(FRAME_LEN);
    localparam logic [P_W-1:0] P_FADE_IN_END  = P_W'(FADE_LEN - 1);
    localparam logic [P_W-1:0] P_FADE_OUT_BEG = P_W'(FRAME_LEN - FADE_LEN);
    localparam logic [P_W-1:0] P_LAST         = P_W'(FRAME_LEN - 1);
    localparam logic [GAIN_SH:0] UNITY        = (GAIN_SH + 1)'(FADE_LEN);

    seam_state_e      state_q, state_d, st_cur;
    logic [P_W-1:0]   p_q, p_d, p_cur;
    logic [GAIN_SH:0] gain;
    logic             seam_now;
    logic [1:0]       seam_q;

    // frame_sync overrides the tracked phase for the sample arriving with it
    always_comb begin
        p_cur    = frame_sync ? '0 : p_q;
        st_cur   = frame_sync ? FADE_IN : state_q;
        gain     = UNITY;
        seam_now = 1'b0;
        p_d      = (st_cur == UNSYNC) ? '0 : p_cur + P_W'(1);
        state_d  = st_cur;
        case (st_cur)
            FADE_IN: begin
                gain     = (GAIN_SH + 1)'(p_cur + P_W'(1));
                seam_now = 1'b1;
                if (p_cur == P_FADE_IN_END)
                    state_d = (p_d == P_FADE_OUT_BEG) ? FADE_OUT : PASS;
            end
            PASS: begin
                if (p_d == P_FADE_OUT_BEG)
                    state_d = FADE_OUT;
            end
            FADE_OUT: begin
                gain     = (GAIN_SH + 1)'(P_LAST - p_cur);
                seam_now = 1'b1;
                if (p_cur == P_LAST)
                    state_d = FADE_IN;
            end
            default: ;
        endcase
        if (!en) begin
            gain     = UNITY;
            seam_now = 1'b0;
        end
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNSYNC;
            p_q     <= '0;
            seam_q  <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            seam_q  <= {seam_q[0], seam_now};
        end
    end

    assign seam_active = seam_q[1];

`ifdef SEAM_STATS_EN
    logic [15:0] seam_cnt_q;

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n)
            seam_cnt_q <= '0;
        else if (en && st_cur == FADE_IN && p_cur == '0)
            seam_cnt_q <= seam_cnt_q + 16'd1;
    end

    assign seam_cnt = seam_cnt_q;
`endif

    seam_gain_mul #(.DATA_WIDTH(DATA_WIDTH), .GAIN_SH(GAIN_SH)) u_mul_l (
        .clk    (sck),
        .rst_n  (rst_n),
        .x_i    (ldata_in),
        .gain_i (gain),
        .y_o    (ldata_out)
    );

    seam_gain_mul #(.DATA_WIDTH(DATA_WIDTH), .GAIN_SH(GAIN_SH)) u_mul_r (
        .clk    (sck),
        .rst_n  (rst_n),
        .x_i    (rdata_in),
        .gain_i (gain),
        .y_o    (rdata_out)
    );

endmodule

// File: tb/tb_frame_seam_smoother.sv
// Randomized bench for frame_seam_smoother against a frame-position reference model.
module tb_frame_seam_smoother;

    localparam int FRAME = 1024;
    localparam int FADE  = 32;

    logic               sck = 1'b0;
    logic               rst_n = 1'b1;
    logic               en = 1'b1;
    logic               frame_sync = 1'b0;
    logic signed [15:0] ldata_in = '0;
    logic signed [15:0] rdata_in = '0;
    logic signed [15:0] ldata_out;
    logic signed [15:0] rdata_out;
    logic               seam_active;
`ifdef SEAM_STATS_EN
    logic [15:0]        seam_cnt;
`endif

    always #5 sck = ~sck;

    frame_seam_smoother dut (
        .sck         (sck),
        .rst_n       (rst_n),
        .en          (en),
        .frame_sync  (frame_sync),
        .ldata_in    (ldata_in),
        .rdata_in    (rdata_in),
        .ldata_out   (ldata_out),
        .rdata_out   (rdata_out),
        .seam_active (seam_active)
`ifdef SEAM_STATS_EN
        ,
        .seam_cnt    (seam_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: frame position, sync flag, and a two-deep output delay line
    int m_p = 0;
    bit m_sync = 1'b0;
    int m_cnt = 0;
    int e1_l = 0, e1_r = 0, e2_l = 0, e2_r = 0;
    bit e1_s = 1'b0, e2_s = 1'b0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t p=%0d)", tag, got, exp, $time, m_p);
        end
    endtask

    function automatic int floor_div32(input int x, input int g);
        int pr, q;
        pr = x * g;
        q  = pr / FADE;
        if (pr < 0 && (pr % FADE) != 0) q = q - 1;
        return q;
    endfunction

    function automatic int rnd();
        logic signed [15:0] v;
        case ($urandom_range(0, 9))
            0:       v = -16'sd32768;
            1:       v = 16'sd32767;
            default: v = 16'($urandom);
        endcase
        return int'(v);
    endfunction

    task automatic cyc(input bit fs, input bit e, input int l, input int r);
        int g, p;
        bit s;
        @(negedge sck);
        frame_sync = fs;
        en         = e;
        ldata_in   = 16'(l);
        rdata_in   = 16'(r);
        @(posedge sck);
        if (fs) begin
            m_sync = 1'b1;
            m_p    = 0;
        end
        p = m_p;
        if (!m_sync)                 g = FADE;
        else if (p < FADE)           g = p + 1;
        else if (p >= FRAME - FADE)  g = FRAME - 1 - p;
        else                         g = FADE;
        s = m_sync && (p < FADE || p >= FRAME - FADE);
        if (!e) begin
            g = FADE;
            s = 1'b0;
        end
        if (e && m_sync && p == 0) m_cnt = (m_cnt + 1) & 16'hFFFF;
        e2_l = e1_l; e2_r = e1_r; e2_s = e1_s;
        e1_l = floor_div32(l, g);
        e1_r = floor_div32(r, g);
        e1_s = s;
        if (m_sync) m_p = (m_p + 1) % FRAME;
        #1;
        chk("ldata_out", ldata_out, e2_l);
        chk("rdata_out", rdata_out, e2_r);
        chk("seam_active", seam_active, e2_s);
`ifdef SEAM_STATS_EN
        chk("seam_cnt", seam_cnt, m_cnt);
`endif
    endtask

    task automatic do_reset();
        frame_sync = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("rst_ldata", ldata_out, 0);
        chk("rst_rdata", rdata_out, 0);
        chk("rst_seam", seam_active, 0);
`ifdef SEAM_STATS_EN
        chk("rst_seam_cnt", seam_cnt, 0);
`endif
        m_sync = 1'b0; m_p = 0; m_cnt = 0;
        e1_l = 0; e1_r = 0; e2_l = 0; e2_r = 0; e1_s = 1'b0; e2_s = 1'b0;
        repeat (3) @(posedge sck);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2 do_reset();

        // unsynced: unity gain
        repeat (20) cyc(1'b0, 1'b1, 1000, -1000);

        // full frame of constant input through fade-in, pass, fade-out and wrap
        cyc(1'b1, 1'b1, 1000, 1000);
        repeat (1100) cyc(1'b0, 1'b1, 1000, 1000);

        // floor of negative products and full-scale negative at unity
        cyc(1'b1, 1'b1, -1000, -1000);
        repeat (30) cyc(1'b0, 1'b1, rnd(), rnd());
        cyc(1'b0, 1'b1, -32768, -32768);

        // frame_sync during fade-out, then a full frame on the new phase
        while (m_p != 1000) cyc(1'b0, 1'b1, rnd(), rnd());
        cyc(1'b1, 1'b1, rnd(), rnd());
        repeat (1100) cyc(1'b0, 1'b1, rnd(), rnd());

        // disable mid fade-in, re-enable at p = 600
        cyc(1'b1, 1'b1, rnd(), rnd());
        repeat (10) cyc(1'b0, 1'b1, rnd(), rnd());
        while (m_p != 600) cyc(1'b0, 1'b0, rnd(), rnd());
        repeat (500) cyc(1'b0, 1'b1, rnd(), rnd());

        // random enable and occasional frame_sync
        repeat (2500) cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, rnd(), rnd());

        // reset in the middle of a frame
        cyc(1'b1, 1'b1, rnd(), rnd());
        while (m_p != 500) cyc(1'b0, 1'b1, rnd(), rnd());
        do_reset();
        repeat (50) cyc(1'b0, 1'b1, rnd(), rnd());

        // three frame starts after reset
        repeat (3) begin
            cyc(1'b1, 1'b1, rnd(), rnd());
            repeat (FRAME - 1) cyc(1'b0, 1'b1, rnd(), rnd());
        end
        repeat (5) cyc(1'b0, 1'b1, rnd(), rnd());
`ifdef SEAM_STATS_EN
        chk("seam_cnt_3", seam_cnt, 4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
